// File: rtl/ram_bridge_pkg.sv
// Shared definitions for the even/odd RAM Wishbone bridge: FSM states,
// RAM read latency and the address-window size helper.
package ram_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        ACK
    } state_t;

    localparam int unsigned RAM_READ_LAT = 1;

    // Bytes covered by both banks together (two banks of 256*cols 32-bit words).
    function automatic int unsigned window_bytes(input int unsigned cols);
        return 2 * 256 * cols * 4;
    endfunction

endpackage

// File: rtl/ram_eo_wb_bridge.sv
// Wishbone classic responder serving accesses from interleaved even/odd word
// RAM banks; one RAM cycle per transfer, fixed ack latency.
module ram_eo_wb_bridge
    import ram_bridge_pkg::*;
#(
    parameter int          COLS     = 4,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    localparam int         BANK_AW  = 8 + $clog2(COLS)
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic               wbs_err_o,
    output logic [31:0]        wbs_dat_o,
    output logic [BANK_AW-1:0] ram_a,
    output logic [31:0]        ram_di,
    output logic [3:0]         ram_we,
    output logic               ram_en_e,
    output logic               ram_en_o,
    input  logic [31:0]        ram_do_e,
    input  logic [31:0]        ram_do_o
);

    // With BASE_ADR aligned to the window, masking the low window bits is the
    // same as comparing wbs_adr_i[31:BANK_AW+3] against the base.
    localparam logic [31:0] WIN_MASK = ~(window_bytes(COLS) - 32'd1);

    state_t      state, state_n;
    logic        bank_sel, bank_sel_n;
    logic        ack_n, err_n;
    logic [31:0] dat_n;
    logic        req, in_win;

    assign req    = wbs_cyc_i & wbs_stb_i;
    assign in_win = ((wbs_adr_i ^ BASE_ADR) & WIN_MASK) == '0;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= IDLE;
            bank_sel  <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            state     <= state_n;
            bank_sel  <= bank_sel_n;
            wbs_ack_o <= ack_n;
            wbs_err_o <= err_n;
            wbs_dat_o <= dat_n;
        end
    end

    always_comb begin
        state_n    = state;
        bank_sel_n = bank_sel;
        ack_n      = 1'b0;
        err_n      = 1'b0;
        dat_n      = '0;
        ram_en_e   = 1'b0;
        ram_en_o   = 1'b0;
        ram_a      = '0;
        ram_di     = '0;
        ram_we     = '0;
        unique case (state)
            IDLE: begin
                // Enables are combinational, so hold them off while in reset.
                if (req && RESETn) begin
                    if (in_win) begin
                        ram_en_e = ~wbs_adr_i[2];
                        ram_en_o = wbs_adr_i[2];
                        ram_a    = wbs_adr_i[BANK_AW+2:3];
                        ram_di   = wbs_dat_i;
                        ram_we   = wbs_we_i ? wbs_sel_i : 4'b0000;
                        if (wbs_we_i) begin
                            ack_n   = 1'b1;
                            state_n = ACK;
                        end else begin
                            bank_sel_n = wbs_adr_i[2];
                            state_n    = RD;
                        end
                    end else begin
                        err_n   = 1'b1;
                        state_n = ACK;
                    end
                end
            end
            RD: begin
                if (!wbs_cyc_i) begin
                    state_n = IDLE;
                end else begin
                    dat_n   = bank_sel ? ram_do_o : ram_do_e;
                    ack_n   = 1'b1;
                    state_n = ACK;
                end
            end
            ACK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_eo_wb_bridge.sv
// Randomized scoreboard bench for ram_eo_wb_bridge with behavioural RAM banks
// and a flat word-array reference model of the address window.
module tb_ram_eo_wb_bridge;

    localparam int          COLS  = 4;
    localparam int          AW    = 10;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int unsigned WORDS = 2 * 256 * COLS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cyc, stb, we;
    logic [3:0]    sel;
    logic [31:0]   adr, dat_w;
    logic          ack, err;
    logic [31:0]   dat_r;
    logic [AW-1:0] ram_a;
    logic [31:0]   ram_di;
    logic [3:0]    ram_we;
    logic          en_e, en_o;
    logic [31:0]   do_e, do_o;

    ram_eo_wb_bridge #(.COLS(COLS), .BASE_ADR(BASE)) dut (
        .CLK(clk), .RESETn(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_w),
        .wbs_ack_o(ack), .wbs_err_o(err), .wbs_dat_o(dat_r),
        .ram_a(ram_a), .ram_di(ram_di), .ram_we(ram_we),
        .ram_en_e(en_e), .ram_en_o(en_o),
        .ram_do_e(do_e), .ram_do_o(do_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Behavioural RAM macros: registered read, byte writes, zero when idle.
    logic [31:0] bank_e [256*COLS];
    logic [31:0] bank_o [256*COLS];
    logic [31:0] ref_mem [WORDS];

    always @(posedge clk) begin
        logic [31:0] w;
        if (en_e) begin
            do_e <= bank_e[ram_a];
            w = bank_e[ram_a];
            for (int b = 0; b < 4; b++) if (ram_we[b]) w[8*b +: 8] = ram_di[8*b +: 8];
            bank_e[ram_a] = w;
        end else begin
            do_e <= '0;
        end
        if (en_o) begin
            do_o <= bank_o[ram_a];
            w = bank_o[ram_a];
            for (int b = 0; b < 4; b++) if (ram_we[b]) w[8*b +: 8] = ram_di[8*b +: 8];
            bank_o[ram_a] = w;
        end else begin
            do_o <= '0;
        end
    end

    typedef struct {
        int unsigned due;
        bit          is_err;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        int unsigned due;
        bit          odd;
        logic [31:0] a;
        logic [3:0]  wen;
        logic [31:0] di;
    } acc_t;

    rsp_t rsp_q[$];
    acc_t acc_q[$];

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned ack_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Monitor: pops expectations whenever the DUT responds or enables a bank.
    always @(negedge clk) begin
        rsp_t r;
        acc_t x;
        while (rsp_q.size() > 0 && rsp_q[0].due < cyc_cnt) begin
            r = rsp_q.pop_front();
            chk("rsp_timeout", 32'(cyc_cnt), 32'(r.due));
        end
        while (acc_q.size() > 0 && acc_q[0].due < cyc_cnt) begin
            x = acc_q.pop_front();
            chk("enable_missing", 32'(cyc_cnt), 32'(x.due));
        end
        if (ack || err) begin
            if (ack) ack_count++;
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", {30'd0, ack, err}, 32'd0);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_cycle", 32'(cyc_cnt), 32'(r.due));
                chk("rsp_kind", {30'd0, ack, err}, r.is_err ? 32'd1 : 32'd2);
                chk("rsp_data", dat_r, r.data);
            end
        end else if (dat_r !== '0) begin
            chk("idle_dat", dat_r, 32'd0);
        end
        if (en_e || en_o) begin
            if (acc_q.size() == 0) begin
                chk("unexpected_enable", {30'd0, en_e, en_o}, 32'd0);
            end else begin
                x = acc_q.pop_front();
                chk("en_cycle", 32'(cyc_cnt), 32'(x.due));
                chk("en_bank", {30'd0, en_e, en_o}, x.odd ? 32'd1 : 32'd2);
                chk("ram_a", 32'(ram_a), x.a);
                chk("ram_we", 32'(ram_we), 32'(x.wen));
                chk("ram_di", ram_di, x.di);
            end
        end
    end

    // Reference model: the window is one flat array of words; bank = idx%2.
    task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input bit want_rsp, output int unsigned lat);
        rsp_t        r;
        acc_t        x;
        int unsigned idx;
        logic [31:0] m;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
        r.due = cyc_cnt; r.is_err = 1'b0; r.data = '0;
        if (a >= BASE && a < BASE + 4 * WORDS) begin
            idx   = (a - BASE) / 4;
            x.due = cyc_cnt;
            x.odd = (idx % 2) == 1;
            x.a   = idx / 2;
            x.wen = w ? s : 4'b0000;
            x.di  = d;
            acc_q.push_back(x);
            if (w) begin
                m = ref_mem[idx];
                for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
                ref_mem[idx] = m;
                lat = 1;
            end else begin
                r.data = ref_mem[idx];
                lat = 2;
            end
        end else begin
            r.is_err = 1'b1;
            lat = 1;
        end
        r.due = r.due + lat;
        if (want_rsp) rsp_q.push_back(r);
    endtask

    task automatic xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit keep);
        int unsigned lat;
        issue(w, a, s, d, 1'b1, lat);
        repeat (lat + 1) @(posedge clk);
        #1;
        if (!keep) begin cyc = 1'b0; stb = 1'b0; end
    endtask

    task automatic idle(input int unsigned n);
        cyc = 1'b0; stb = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned lat;
        int unsigned acks0;
        logic [31:0] a;
        for (int unsigned i = 0; i < WORDS; i++) ref_mem[i] = $urandom;
        for (int unsigned i = 0; i < WORDS / 2; i++) begin
            bank_e[i] = ref_mem[2*i];
            bank_o[i] = ref_mem[2*i+1];
        end
        cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_w = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_dat", dat_r, 32'd0);
        chk("rst_en", {30'd0, en_e, en_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        xfer(1, 32'h3000_0004, 4'hF, 32'hDEAD_BEEF, 0);
        xfer(0, 32'h3000_0004, 4'hF, 32'h0, 0);
        idle(2);

        ref_mem[2] = 32'h1122_3344;
        bank_e[1]  = 32'h1122_3344;
        xfer(1, 32'h3000_0008, 4'b0100, 32'h00AA_0000, 0);
        xfer(0, 32'h3000_0008, 4'hF, 32'h0, 0);
        idle(1);

        xfer(0, 32'h3000_2000, 4'hF, 32'h0, 0);
        xfer(1, 32'h2FFF_FFFC, 4'hF, 32'h1234_5678, 0);
        idle(2);

        acks0 = ack_count;
        for (int unsigned i = 0; i < 4; i++)
            xfer(1, 32'h3000_0100 + 4 * i, 4'hF, $urandom, i != 3);
        idle(2);
        chk("b2b_acks", ack_count - acks0, 32'd4);

        // Drop cyc while waiting on the bank: no ack may follow.
        issue(0, 32'h3000_0010, 4'hF, 32'h0, 0, lat);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        idle(4);

        // Reset in RD.
        issue(0, 32'h3000_0014, 4'hF, 32'h0, 0, lat);
        @(posedge clk); #1;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
        #1;
        chk("rd_rst_ack", {31'd0, ack}, 32'd0);
        chk("rd_rst_dat", dat_r, 32'd0);
        chk("rd_rst_en", {30'd0, en_e, en_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);

        // Reset in the ACK cycle of a read with nonzero data.
        ref_mem[9] = 32'hA5A5_0001;
        bank_o[4]  = 32'hA5A5_0001;
        issue(0, 32'h3000_0024, 4'hF, 32'h0, 0, lat);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_ack", {31'd0, ack}, 32'd1);
        chk("pre_rst_dat", dat_r, 32'hA5A5_0001);
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
        #1;
        chk("ack_rst_ack", {31'd0, ack}, 32'd0);
        chk("ack_rst_dat", dat_r, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);

        for (int unsigned i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0)
                a = (($urandom_range(0, 1) == 0) ? BASE + 32'h2000 : BASE - 32'h4) + {$urandom_range(0, 255), 2'b00};
            else
                a = BASE + {$urandom_range(0, WORDS - 1), 2'b00} + 32'($urandom_range(0, 3));
            xfer($urandom_range(0, 1) == 1, a, 4'($urandom), $urandom, $urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(6);

        chk("rsp_q_empty", rsp_q.size(), 32'd0);
        chk("acc_q_empty", acc_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_eo_wb_bridge.md
# ram_eo_wb_bridge

Wishbone classic responder that serves bus accesses from a pair of interleaved single-port RAM banks (even and odd word banks). Each bank has a registered read port, per-byte write enables and an active-high enable, and the bank drives zero on its read port when not enabled. The bridge decodes the address window and steers each access to the correct bank. It issues exactly one RAM cycle per bus transfer and returns data and an acknowledge with fixed latency. It sits between the user-project Wishbone bus and the even/odd RAM macros.

## Interface
- `COLS`, default 4: bank depth in units of 256 words. Each bank holds 256*COLS words.
- `BANK_AW`, default 8+$clog2(COLS): bank word-address width. This is a localparam, not overridable.
- `BASE_ADR`, default 32'h3000_0000: window base. It must be aligned to the window size, which is 2*256*COLS*4 bytes.
- `CLK`  in  1: clock. All logic is on the rising edge.
- `RESETn`  in  1: asynchronous, active-low reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each: Wishbone cycle, strobe and write.
- `wbs_sel_i`  in  4: byte selects.
- `wbs_adr_i`  in  32: byte address.
- `wbs_dat_i`  in  32: write data.
- `wbs_ack_o`  out  1: transfer acknowledge.
- `wbs_err_o`  out  1: error for an out-of-window access.
- `wbs_dat_o`  out  32: read data.
- `ram_a`  out  BANK_AW: word address, shared by both banks.
- `ram_di`  out  32: write data, shared by both banks.
- `ram_we`  out  4: byte write enables, shared by both banks.
- `ram_en_e`, `ram_en_o`  out  1 each: even-bank and odd-bank enables.
- `ram_do_e`, `ram_do_o`  in  32 each: bank read data. It is valid the cycle after the enable and zero otherwise.

## Operation
- Address decode:
  - Request condition: `req = wbs_cyc_i & wbs_stb_i`.
  - In-window condition: `wbs_adr_i[31:BANK_AW+3] == BASE_ADR[31:BANK_AW+3]`.
  - Bank select: `wbs_adr_i[2]`. 0 selects the even bank, 1 selects the odd bank.
  - Word address: `ram_a = wbs_adr_i[BANK_AW+2:3]`.
  - `wbs_adr_i[1:0]` is ignored.
- FSM states:
  - IDLE, from reset.
  - RD: waiting for the bank's registered output.
  - ACK: the ack or err cycle.
- IDLE with req and in-window:
  - Drive the enable of the selected bank for exactly this cycle, combinationally from the inputs.
  - Drive `ram_a` and `ram_di = wbs_dat_i`.
  - `ram_we` is `wbs_sel_i` when `wbs_we_i` is high, otherwise 4'b0000.
  - For a write, go to ACK with ack pending. For a read, latch the bank select and go to RD.
- IDLE with req and out-of-window: no RAM enable; go to ACK with err pending.
- RD:
  - Register the latched bank's output: `wbs_dat_o <= bank_sel ? ram_do_o : ram_do_e`.
  - Go to ACK.
- ACK:
  - `wbs_ack_o` (or `wbs_err_o`) is high for exactly one cycle. Both are registered outputs.
  - Go to IDLE. No new request is sampled in the ACK cycle.
- `wbs_dat_o` is nonzero only in a read's ACK cycle. It is cleared to zero in every other cycle.
- A write with `wbs_sel_i = 0` still enables the bank with `ram_we = 0` and is acked.
- If `wbs_cyc_i` drops while in RD:
  - Go to IDLE and suppress the ack.
  - A write already issued to the RAM is not undone.
- RAM outputs (`ram_a`, `ram_di`, `ram_we`) are don't-care whenever both enables are low. The implementation drives them to zero in that case.
- There are no outstanding or pipelined requests: one transfer is in flight at most.

## Timing
- Reset: state IDLE. `wbs_ack_o`, `wbs_err_o`, `wbs_dat_o` are 0. Both enables are 0. Reset takes effect immediately and asynchronously.
- Write: request at cycle 0 with RAM enable in the same cycle; `wbs_ack_o` in cycle 1.
- Read: request and enable at cycle 0; bank data at cycle 1; `wbs_ack_o` and `wbs_dat_o` in cycle 2.
- Error: `wbs_err_o` in cycle 1.
- Back-to-back with stb held high: the next request is accepted in the cycle after ACK.
  - Minimum spacing is 2 cycles per write and 3 cycles per read.
- Reset asserted during RD or ACK:
  - All outputs go to zero at once.
  - No ack or err is issued after `RESETn` is released.

## Structure
- A shared package `ram_bridge_pkg` holds:
  - the state enum (IDLE, RD, ACK);
  - constant `RAM_READ_LAT = 1`;
  - the window-size function of COLS.
- No sub-module. Decode, FSM and data mux are in a single module.

## Test plan
All scenarios use COLS=4 and BASE=32'h3000_0000, so the window is 0x3000_0000–0x3000_1FFF. The bench uses a behavioural bank model.

1. Full-word write: write 0xDEADBEEF, sel 4'hF, to address 0x3000_0004 -> in cycle 0, `ram_en_o=1`, `ram_en_e=0`, `ram_a=0`, `ram_we=4'hF`, `ram_di=0xDEADBEEF`; ack in cycle 1.
2. Read-back: read 0x3000_0004 -> `ram_en_o` pulses in cycle 0 with `ram_we=0`; in cycle 2, `wbs_dat_o=0xDEADBEEF` with ack; in cycle 3, `wbs_dat_o=0`.
3. Byte write: preload even word 1 with 0x11223344; write 0x00AA0000, sel 4'b0100, to 0x3000_0008 -> `ram_en_e=1`, `ram_a=1`, `ram_we=4'b0100`; a subsequent read returns 0x11AA3344.
4. Out-of-window: read 0x3000_2000 -> `wbs_err_o=1` in cycle 1 only; no enables asserted; ack stays 0.
5. Back-to-back: stb held for 4 alternating even/odd writes -> exactly 4 acks, each 2 cycles apart; each bank enable pulses once per transfer.
6. Reset and abort:
   - Assert `RESETn=0` in RD -> outputs go to 0 immediately; no ack after release.
   - Separately, drop cyc in RD -> state returns to IDLE and no ack is issued.
